fetch_pc: RTL and testbench

Instruction-fetch front end of the one-cycle core, directly upstream of the instruction memory. Holds the program counter, drives the word address into the combinational instruction memory and hands the returned instruction plus its PC to decode over a valid/ready handshake. Handles redirects (branch/jump/trap targets), decode back-pressure and halt, and keeps a retired-fetch counter.

---
 rtl/fetch_pc.sv | 125 ++++++++++++
 tb/tb_fetch_pc.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc.sv
// fetch_pc: instruction-fetch front end of the one-cycle core.
// Holds the PC and drives the word index into a combinational instruction memory.
// Hands each instruction and its PC to decode over a valid/ready handshake.
// Handles redirects, decode back-pressure and halt, and counts completed handshakes.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN. When it is defined, a misaligned
// redirect target enters a TRAP state instead of being silently word-aligned.
module fetch_pc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic               halt_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_inst,
  output logic               fd_valid,
  input  logic               fd_ready,
  output logic [31:0]        fd_pc,
  output logic [31:0]        fd_inst,
  output logic               halted,
  output logic               misalign_fault,
  output logic [31:0]        fetch_cnt
);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {StBoot = 2'd0, StRun = 2'd1, StHalt = 2'd2, StTrap = 2'd3} state_e;
`else
  typedef enum logic [1:0] {StBoot = 2'd0, StRun = 2'd1, StHalt = 2'd2} state_e;
`endif

  state_e      r_state;
  state_e      w_state_d;
  logic [31:0] r_pc;
  logic [31:0] w_pc_d;
  logic [31:0] r_fetch_cnt;
  logic        w_fire;
  logic [31:0] w_redir_pc;
  state_e      w_redir_state;

  // Where a redirect lands: target PC and the state it leads to.
`ifdef FETCH_MISALIGN_TRAP_EN
  always_comb begin
    w_redir_pc    = redirect_pc;
    w_redir_state = (redirect_pc[1:0] != 2'b00) ? StTrap : StRun;
  end
`else
  always_comb begin
    // Low bits are dropped so the PC can never become misaligned.
    w_redir_pc    = redirect_pc & 32'hFFFF_FFFC;
    w_redir_state = StRun;
  end
`endif

  // Next-state / next-PC logic and handshake valid.
  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    fd_valid  = 1'b0;
    case (r_state)
      StBoot: begin
        w_state_d = StRun;
      end
      StRun: begin
        // A redirect kills the instruction currently on offer.
        fd_valid = !redirect_valid;
        if (redirect_valid) begin
          w_pc_d    = w_redir_pc;
          w_state_d = w_redir_state;
        end else if (halt_req) begin
          w_state_d = StHalt;
        end else if (fd_ready) begin
          w_pc_d = r_pc + 32'd4;
        end
      end
      StHalt: begin
        if (redirect_valid) begin
          w_pc_d    = w_redir_pc;
          w_state_d = w_redir_state;
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      StTrap: begin
        if (redirect_valid) begin
          w_pc_d    = w_redir_pc;
          w_state_d = w_redir_state;
        end
      end
`endif
      default: begin
        w_state_d = StBoot;
      end
    endcase
  end

  assign w_fire = fd_valid && fd_ready;

  // State, PC and retired-fetch counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StBoot;
      r_pc        <= RESET_PC;
      r_fetch_cnt <= 32'd0;
    end else begin
      r_state <= w_state_d;
      r_pc    <= w_pc_d;
      if (w_fire) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
    end
  end

  assign imem_addr = r_pc[IMEM_AW+1:2];
  assign fd_pc     = r_pc;
  assign fd_inst   = imem_inst;
  assign halted    = (r_state == StHalt);
  assign fetch_cnt = r_fetch_cnt;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign misalign_fault = (r_state == StTrap);
`else
  assign misalign_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc.sv
// tb_fetch_pc: directed and random checking of fetch_pc against a behavioural model.
module tb_fetch_pc;
  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam int unsigned ImemAw  = 10;

  localparam int MBoot = 0;
  localparam int MRun  = 1;
  localparam int MHalt = 2;
  localparam int MTrap = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              redirect_valid = 1'b0;
  logic [31:0]       redirect_pc = 32'h0;
  logic              halt_req = 1'b0;
  logic [ImemAw-1:0] imem_addr;
  logic [31:0]       imem_inst;
  logic              fd_valid;
  logic              fd_ready = 1'b0;
  logic [31:0]       fd_pc;
  logic [31:0]       fd_inst;
  logic              halted;
  logic              misalign_fault;
  logic [31:0]       fetch_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  fetch_pc #(
    .RESET_PC(ResetPc),
    .IMEM_AW (ImemAw)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt_req      (halt_req),
    .imem_addr     (imem_addr),
    .imem_inst     (imem_inst),
    .fd_valid      (fd_valid),
    .fd_ready      (fd_ready),
    .fd_pc         (fd_pc),
    .fd_inst       (fd_inst),
    .halted        (halted),
    .misalign_fault(misalign_fault),
    .fetch_cnt     (fetch_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [ImemAw-1:0] a);
    logic [31:0] w;
    w = 32'(a);
    return (w << 20) ^ 32'h1357_9BDF ^ (w * 32'd7);
  endfunction

  // Combinational instruction memory.
  assign imem_inst = inst_of(imem_addr);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_valid();
    return (m_mode == MRun) && !redirect_valid;
  endfunction

  task automatic check_all();
    logic [31:0] word_addr;
    word_addr = m_pc >> 2;
    check_eq("fd_valid", 32'(fd_valid), 32'(model_valid()));
    check_eq("fd_pc", fd_pc, m_pc);
    check_eq("imem_addr", 32'(imem_addr), word_addr % (32'd1 << ImemAw));
    check_eq("fd_inst", fd_inst, inst_of(word_addr[ImemAw-1:0]));
    check_eq("halted", 32'(halted), 32'(m_mode == MHalt));
    check_eq("misalign_fault", 32'(misalign_fault), 32'(m_mode == MTrap));
    check_eq("fetch_cnt", fetch_cnt, m_cnt);
  endtask

  // Where a redirect takes the model.
  task automatic model_load(input logic [31:0] tgt);
`ifdef FETCH_MISALIGN_TRAP_EN
    m_pc   = tgt;
    m_mode = (tgt % 4 != 0) ? MTrap : MRun;
`else
    m_pc   = tgt - (tgt % 4);
    m_mode = MRun;
`endif
  endtask

  task automatic model_step();
    if (model_valid() && fd_ready) m_cnt = m_cnt + 1;
    case (m_mode)
      MBoot: m_mode = MRun;
      MRun: begin
        if (redirect_valid) model_load(redirect_pc);
        else if (halt_req) m_mode = MHalt;
        else if (fd_ready) m_pc = m_pc + 4;
      end
      default: if (redirect_valid) model_load(redirect_pc);
    endcase
  endtask

  // Apply inputs at the falling edge, check mid-cycle, advance one clock.
  task automatic cyc(input logic rv, input logic [31:0] rpc, input logic hr, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt_req       = hr;
    fd_ready       = rdy;
    #1;
    check_all();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    m_mode = MBoot;
    m_pc   = ResetPc;
    m_cnt  = 32'd0;
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] held_inst;
    logic [31:0] rpc;
    #1;
    do_reset();

    // Boot cycle, then stream 0,4 and stall at 8.
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    held_inst = fd_inst;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 32'h0, 1'b0, 1'b0);
      check_eq("stall_inst", fd_inst, held_inst);
    end
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("cnt_after_four", fetch_cnt, 32'd4);
    check_eq("pc_after_four", fd_pc, 32'h10);

    // Redirect kills 0x10.
    cyc(1'b1, 32'h100, 1'b0, 1'b1);
    check_eq("redir_target", fd_pc, 32'h100);
    check_eq("redir_no_count", fetch_cnt, 32'd4);

    // Halt at 0x20 with accept, then resume at 0x40.
    cyc(1'b1, 32'h20, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b1);
    check_eq("halt_rise", 32'(halted), 32'd1);
    check_eq("halt_count", fetch_cnt, 32'd5);
    cyc(1'b0, 32'h0, 1'b1, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b1, 32'h40, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);

    // PC wrap at the top of the address space.
    cyc(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);
    check_eq("pc_wrap", fd_pc, 32'h0);

    // Reset in the middle of a stall.
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    redirect_valid = 1'b0;
    fd_ready       = 1'b0;
    do_reset();
    cyc(1'b1, 32'h300, 1'b1, 1'b1);  // boot ignores redirect and halt
    cyc(1'b0, 32'h0, 1'b0, 1'b1);

    // Misaligned redirect.
    cyc(1'b1, 32'h102, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b0, 1'b1);
    cyc(1'b1, 32'h200, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rpc = $urandom();
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      cyc(($urandom_range(0, 7) == 0), rpc, ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 1) == 1));
      if ($urandom_range(0, 199) == 0) begin
        redirect_valid = 1'b0;
        do_reset();
      end
    end
    cyc(1'b0, 32'h0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
